bus_xfer_arbiter: RTL
=====================

# bus_xfer_arbiter

Parametrised multi-source bus transfer unit with arbitration. NSRC sources, each WIDTH bits wide, share one registered output bus. Sources present packets with a valid/ready/last handshake. The block grants one source at a time, in round-robin or fixed-priority order, and holds the grant until that source's last beat is accepted. It sits between the datapath register sources and the shared system bus, replacing the unregistered select-driven bus mux.

## Interface
Parameters:
- WIDTH, 4, data bits per source and on the bus
- NSRC, 4, number of sources (2..16)
- SRC_W, $clog2(NSRC), derived; width of the source index (not overridden)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- src_data  in  NSRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- src_valid  in  NSRC  source i has a beat
- src_last  in  NSRC  source i's current beat ends its packet
- src_ready  out  NSRC  beat of source i accepted this cycle when valid&ready
- mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest); sampled only in IDLE
- bus_data  out  WIDTH  registered bus data
- bus_valid  out  1  bus_data holds a beat
- bus_last  out  1  registered copy of the source's last flag
- bus_src  out  SRC_W  index of the source that produced the bus beat
- bus_ready  in  1  downstream accepts the bus beat when bus_valid&bus_ready

## Operation
- States: IDLE, GRANT.
- IDLE:
  - src_ready = 0.
  - If any src_valid is high, select a winner, register owner = winner, and go to GRANT.
  - Round-robin: the first valid index at or above ptr, wrapping modulo NSRC.
  - Fixed priority: the lowest valid index.
- GRANT:
  - src_ready[owner] = (!bus_valid || bus_ready). All other bits are 0.
  - On acceptance (src_valid[owner] & src_ready[owner]), the output register loads bus_data = owner's data, bus_last = src_last[owner], bus_src = owner, bus_valid = 1.
  - If src_valid[owner] drops mid-packet, the grant is held. No timeout.
  - An accepted beat with last = 1 returns the block to IDLE and sets ptr = (owner+1) mod NSRC. In fixed-priority mode ptr is also updated but ignored.
- Output register:
  - If bus_valid & bus_ready and no new beat is loaded, bus_valid clears to 0. bus_data, bus_last and bus_src hold their values.
  - A load and a drain in the same cycle gives back-to-back beats with no bubble.
- A change on mode while in GRANT has no effect until the next IDLE.
- A beat that is valid with last = 1 is a single-beat packet.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - State = IDLE, ptr = 0, owner = 0.
  - bus_valid, bus_last, bus_data and bus_src = 0. src_ready = 0.
  - Reset mid-packet discards the partial packet and any pending bus beat.
- Arbitration costs 1 cycle:
  - Edge N: valid is seen in IDLE.
  - Cycle after N: GRANT with src_ready high.
  - Beat accepted at edge N+1, so bus_valid is high after edge N+1.
- Packet-to-packet gap: at least 1 IDLE cycle between a last beat and the next grant.
- Sustained throughput in GRANT with bus_ready held at 1: 1 beat per cycle.
- Backpressure: bus_ready = 0 while bus_valid = 1 drops src_ready[owner] combinationally in the same cycle. No beat is lost or duplicated.
- src_ready depends combinationally only on state, owner and bus_valid/bus_ready. It never depends on src_valid, so there is no loop.

## Structure
- Shared package bus_pkg:
  - state enum (IDLE, GRANT)
  - mode constants MODE_RR = 1'b0 and MODE_FIXED = 1'b1
- Sub-module rr_picker:
  - Parameter NSRC; inputs req[NSRC], ptr[SRC_W], mode.
  - Outputs any and idx[SRC_W].
  - Purely combinational rotate-and-priority-encode.
- The top level holds the FSM, the owner/ptr registers and the output register.

## Test plan
All scenarios use NSRC = 4 and WIDTH = 4.
- Reset: assert rst_n = 0 for 2 cycles with all src_valid = 1 -> bus_valid = 0, bus_data = 0000, src_ready = 0000. First grant goes to src 0 in cycle 2 after release.
- Round-robin fairness:
  - Stimulus: all 4 sources send continuous single-beat packets with data a = 0000, b = 0001, c = 1000, d = 1111, bus_ready = 1.
  - Required: bus_src sequence 0,1,2,3,0..., bus_data 0000, 0001, 1000, 1111, with one IDLE bubble between beats.
- Fixed priority: mode = 1, src 0 and src 3 continuously valid -> bus_src is always 0. src 3 is granted only after src 0 deasserts valid.
- Multi-beat lock:
  - Stimulus: src 1 sends a 3-beat packet 0001, 0010, 0011 (last on beat 3) while src 2 is valid.
  - Required: three consecutive bus beats from src 1 with bus_last only on beat 3, then src 2 is granted.
- Backpressure: bus_ready = 0 for 3 cycles mid-packet -> bus_data is stable, src_ready[owner] = 0. After release the remaining beats arrive in order with no loss or duplication.
- Reset mid-packet: rst_n = 0 after beat 2 of a 3-beat packet -> next cycle bus_valid = 0 and state is IDLE. After release arbitration restarts with ptr = 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the bus transfer arbiter: FSM state encoding and arbitration mode values.
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/bus_xfer_arbiter_rr_picker.sv
// Combinational winner select: first request at/above ptr (wrapping) in round-robin,
// lowest index in fixed priority. No state, no handshake.
module rr_picker #(
  parameter int NSRC  = 4,
  parameter int SRC_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  input  logic             mode,
  output logic             any,
  output logic [SRC_W-1:0] idx
);
  import bus_pkg::*;

  logic [SRC_W-1:0] base;
  logic [SRC_W-1:0] cand;
  logic             found;
  int               sum;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    sum   = 0;
    base  = (mode == MODE_FIXED) ? '0 : ptr;
    // Walk NSRC slots starting at base; the first requester found wins.
    for (int k = 0; k < NSRC; k++) begin
      sum = int'(base) + k;
      if (sum >= NSRC) sum = sum - NSRC;
      cand = SRC_W'(sum);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_arbiter.sv
// Packet arbiter onto one registered bus; 1 cycle arbitration, then 1 beat/cycle while granted.
// src_ready of the owner follows (!bus_valid || bus_ready) combinationally, so stalls lose no beats.
module bus_xfer_arbiter #(
  parameter int WIDTH = 4,
  parameter int NSRC  = 4,
  parameter int SRC_W = $clog2(NSRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC-1:0]         src_last,
  output logic [NSRC-1:0]         src_ready,
  input  logic                    mode,
  output logic [WIDTH-1:0]        bus_data,
  output logic                    bus_valid,
  output logic                    bus_last,
  output logic [SRC_W-1:0]        bus_src,
  input  logic                    bus_ready
);
  import bus_pkg::*;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] owner, ptr, pick_idx;
  logic             pick_any, bus_free, accept;
  logic [WIDTH-1:0] src_word [NSRC];

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*WIDTH +: WIDTH];
  end

  rr_picker #(
    .NSRC  (NSRC),
    .SRC_W (SRC_W)
  ) u_picker (
    .req  (src_valid),
    .ptr  (ptr),
    .mode (mode),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign bus_free = !bus_valid || bus_ready;

  always_comb begin
    state_nxt = state;
    src_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = GRANT;
      end
      GRANT: begin
        src_ready[owner] = bus_free;
        accept           = src_valid[owner] && bus_free;
        if (accept && src_last[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      bus_valid <= 1'b0;
      bus_data  <= '0;
      bus_last  <= 1'b0;
      bus_src   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) owner <= pick_idx;
      if (accept && src_last[owner])
        ptr <= (owner == SRC_W'(NSRC - 1)) ? '0 : owner + SRC_W'(1);
      // A load takes precedence over a drain, giving back-to-back beats.
      if (accept) begin
        bus_valid <= 1'b1;
        bus_data  <= src_word[owner];
        bus_last  <= src_last[owner];
        bus_src   <= owner;
      end else if (bus_valid && bus_ready) begin
        bus_valid <= 1'b0;
      end
    end
  end

endmodule
